// File: rtl/binarysearch_pkg.sv
// Shared types and per-state control constants for the binary-search controller.
// The datapath bench imports the same constants so both sides agree on encodings.
package binarysearch_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_GETMEM  = 3'd2,
        S_COMPUTE = 3'd3,
        S_CHECK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    typedef struct packed {
        logic set_l;
        logic set_r;
        logic set_m;
        logic load_a;
        logic done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE    = 5'b00000;
    localparam ctrl_t CTRL_INIT    = 5'b11010;
    localparam ctrl_t CTRL_GETMEM  = 5'b00100;
    localparam ctrl_t CTRL_COMPUTE = 5'b11100;
    localparam ctrl_t CTRL_CHECK   = 5'b00100;
    localparam ctrl_t CTRL_DONE    = 5'b00001;

    // Moore decode of the datapath control lines for a given state.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        case (s)
            S_INIT:    c = CTRL_INIT;
            S_GETMEM:  c = CTRL_GETMEM;
            S_COMPUTE: c = CTRL_COMPUTE;
            S_CHECK:   c = CTRL_CHECK;
            S_DONE:    c = CTRL_DONE;
            default:   c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/binarysearch_rising_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse the cycle after `in` rises.
// A level held high produces a single pulse.
module rising_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;
    logic pulse_q;
    logic pulse_d;

    // Next values: track the input level and flag a low-to-high transition.
    always_comb begin
        in_d    = in;
        pulse_d = in & ~in_q;
    end

    // Edge-detect registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            in_q    <= in_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/binarysearch_ctrl.sv
// Control FSM sequencing the binary-search datapath.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for first start edge, all control lines low
//   S_INIT    | load L/R bounds and capture search value, clear iter/timeout
//   S_GETMEM  | wait RD_LAT cycles for RAM read at M
//   S_COMPUTE | move L or R according to comparison, count one pass
//   S_CHECK   | decide: found/not-found/iteration limit -> DONE, else probe
//   S_DONE    | result held until the next start edge
//
// All outputs come from flops loaded with the decode of the next state, so
// nothing combinational reaches them from F/NF.
module binarysearch_ctrl
    import binarysearch_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LAT     = 1,
    parameter int MAX_ITER   = ADDR_WIDTH + 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic F,
    input  logic NF,
    output logic set_L,
    output logic set_R,
    output logic set_M,
    output logic load_A,
    output logic done,
    output logic busy,
    output logic timeout
);

    localparam int ITER_W = $clog2(MAX_ITER + 1);
    localparam int RD_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);
    localparam logic [RD_W-1:0]   RD_FIRST = RD_W'(RD_LAT - 1);

    state_t            state_q,   state_d;
    ctrl_t             ctrl_q,    ctrl_d;
    logic              busy_q,    busy_d;
    logic              timeout_q, timeout_d;
    logic [ITER_W-1:0] iter_q,    iter_d;
    logic [RD_W-1:0]   rd_cnt_q,  rd_cnt_d;

    logic start_pulse;
    logic found;

    rising_edge_detect u_start_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (start),
        .pulse   (start_pulse)
    );

    assign found = F | NF;

    // Next-state, counters and registered-output decode.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        rd_cnt_d  = rd_cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start_pulse) state_d = S_INIT;
            end
            S_INIT: begin
                state_d = S_GETMEM;
            end
            S_GETMEM: begin
                // NF can rise as soon as set_M sees L>R; leave on the first read cycle.
                if ((rd_cnt_q == RD_FIRST) && found) begin
                    state_d = S_DONE;
                end else if (rd_cnt_q == '0) begin
                    state_d = S_COMPUTE;
                end else begin
                    rd_cnt_d = rd_cnt_q - RD_W'(1);
                end
            end
            S_COMPUTE: begin
                state_d = S_CHECK;
                if (iter_q != ITER_MAX) iter_d = iter_q + ITER_W'(1);
            end
            S_CHECK: begin
                if (found) begin
                    state_d = S_DONE;
                end else if (iter_q == ITER_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_GETMEM;
                end
            end
            S_DONE: begin
                if (start_pulse) state_d = S_INIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_INIT) begin
            iter_d    = '0;
            timeout_d = 1'b0;
        end

        // Dwell counter reloads every time a read window opens.
        if ((state_d == S_GETMEM) && (state_q != S_GETMEM)) rd_cnt_d = RD_FIRST;

        ctrl_d = ctrl_of(state_d);
        busy_d = state_d inside {S_INIT, S_GETMEM, S_COMPUTE, S_CHECK};
    end

    // State, counters and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= CTRL_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            iter_q    <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            iter_q    <= iter_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign set_L   = ctrl_q.set_l;
    assign set_R   = ctrl_q.set_r;
    assign set_M   = ctrl_q.set_m;
    assign load_A  = ctrl_q.load_a;
    assign done    = ctrl_q.done;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_binarysearch_ctrl.sv
// Directed bench for binarysearch_ctrl with a behavioural F/NF responder.
// Vector order used throughout: {set_L, set_R, set_M, load_A, done, busy, timeout}.
module tb_binarysearch_ctrl;

    localparam logic [6:0] V_IDLE    = 7'b0000000;
    localparam logic [6:0] V_INIT    = 7'b1101010;
    localparam logic [6:0] V_GETMEM  = 7'b0010010;
    localparam logic [6:0] V_COMPUTE = 7'b1110010;
    localparam logic [6:0] V_CHECK   = 7'b0010010;
    localparam logic [6:0] V_DONE    = 7'b0000100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic f       = 1'b0;
    logic nf      = 1'b0;
    logic set_l, set_r, set_m, load_a, done, busy, timeout;

    logic start3 = 1'b0;
    logic f3     = 1'b0;
    logic nf3    = 1'b0;
    logic set_l3, set_r3, set_m3, load_a3, done3, busy3, timeout3;

    int checks = 0;
    int errors = 0;

    int target    = 0;
    int nf_mode   = 0;
    int comp_seen = 0;

    binarysearch_ctrl #(.ADDR_WIDTH(5), .RD_LAT(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .F       (f),
        .NF      (nf),
        .set_L   (set_l),
        .set_R   (set_r),
        .set_M   (set_m),
        .load_A  (load_a),
        .done    (done),
        .busy    (busy),
        .timeout (timeout)
    );

    binarysearch_ctrl #(.ADDR_WIDTH(5), .RD_LAT(3)) dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start3),
        .F       (f3),
        .NF      (nf3),
        .set_L   (set_l3),
        .set_R   (set_r3),
        .set_M   (set_m3),
        .load_A  (load_a3),
        .done    (done3),
        .busy    (busy3),
        .timeout (timeout3)
    );

    // Datapath stand-in: reinitialises on INIT, raises F after the target-th COMPUTE,
    // or raises NF straight after INIT when nf_mode is set.
    always @(negedge clock) begin
        if (load_a) begin
            comp_seen = 0;
            f         = 1'b0;
            nf        = (nf_mode != 0);
        end else if (set_l && set_r && set_m) begin
            comp_seen++;
            if (target != 0 && comp_seen == target) f = 1'b1;
        end
    end

    function automatic logic [6:0] obs();
        return {set_l, set_r, set_m, load_a, done, busy, timeout};
    endfunction

    function automatic logic [6:0] obs3();
        return {set_l3, set_r3, set_m3, load_a3, done3, busy3, timeout3};
    endfunction

    // Raise start just after a falling edge; the next rising edge is edge k.
    task automatic start_edge();
        @(negedge clock);
        start = 1'b1;
    endtask

    // Cycles after edge k until done (-1 if the bound expires), plus COMPUTE count.
    task automatic wait_done(input int limit, output int n, output int comps);
        n     = -1;
        comps = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock);
            #1;
            if (set_l && set_r && set_m) comps++;
            if (i > 0 && done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), V_IDLE);
        end
        checks++;
        if (obs3() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs_rdlat3: got %b expected %b", obs3(), V_IDLE);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL idle_after_release: got %b expected %b", obs(), V_IDLE);
        end
    endtask

    task automatic test_found_first();
        logic [6:0] exp_v [6];
        exp_v = '{V_IDLE, V_INIT, V_GETMEM, V_COMPUTE, V_CHECK, V_DONE};
        target  = 1;
        nf_mode = 0;
        start_edge();
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL found_first_seq[k+%0d]: got %b expected %b", i, obs(), exp_v[i]);
            end
        end
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (obs() !== V_DONE) begin
            errors++;
            $display("FAIL found_first_hold: got %b expected %b", obs(), V_DONE);
        end
    endtask

    task automatic test_found_fifth();
        int n, comps;
        target = 5;
        start_edge();
        wait_done(100, n, comps);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL fifth_done_cycle: got %0d expected 17", n);
        end
        checks++;
        if (comps !== 5) begin
            errors++;
            $display("FAIL fifth_compute_count: got %0d expected 5", comps);
        end
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL fifth_timeout: got %b expected 0", timeout);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_timeout();
        int n, comps;
        target = 0;
        start_edge();
        wait_done(100, n, comps);
        checks++;
        if (n !== 23) begin
            errors++;
            $display("FAIL timeout_done_cycle: got %0d expected 23", n);
        end
        checks++;
        if (comps !== 7) begin
            errors++;
            $display("FAIL timeout_compute_count: got %0d expected 7", comps);
        end
        checks++;
        if (obs() !== {V_DONE[6:1], 1'b1}) begin
            errors++;
            $display("FAIL timeout_flag: got %b expected %b", obs(), {V_DONE[6:1], 1'b1});
        end
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
        target = 1;
        start_edge();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (obs() !== V_INIT) begin
            errors++;
            $display("FAIL timeout_cleared_in_init: got %b expected %b", obs(), V_INIT);
        end
        wait_done(20, n, comps);
        checks++;
        if (n !== 3 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rerun_after_timeout: got n=%0d timeout=%b expected n=3 timeout=0", n, timeout);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_back_to_back();
        int n_init, done_at, n, comps;
        // Level held for 50 cycles: exactly one search.
        target  = 2;
        n_init  = 0;
        done_at = -1;
        start_edge();
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            if (load_a) n_init++;
            if (i > 0 && done && done_at < 0) done_at = i;
        end
        checks++;
        if (n_init !== 1 || done_at !== 8) begin
            errors++;
            $display("FAIL held_start: got inits=%0d done_at=%0d expected inits=1 done_at=8", n_init, done_at);
        end
        // Second rising edge while busy is dropped.
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
        target  = 3;
        n_init  = 0;
        done_at = -1;
        start_edge();
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (load_a) n_init++;
            if (i > 0 && done && done_at < 0) done_at = i;
            if (i == 3) start = 1'b0;
            if (i == 5) start = 1'b1;
        end
        checks++;
        if (n_init !== 1 || done_at !== 11) begin
            errors++;
            $display("FAIL busy_edge_ignored: got inits=%0d done_at=%0d expected inits=1 done_at=11", n_init, done_at);
        end
        // Rising edge in DONE restarts.
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
        target = 1;
        start_edge();
        wait_done(20, n, comps);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL restart_from_done: got %0d expected 5", n);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_nf_getmem();
        int n, comps;
        target  = 0;
        nf_mode = 1;
        start_edge();
        wait_done(20, n, comps);
        checks++;
        if (n !== 3 || comps !== 0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL nf_in_getmem: got n=%0d comps=%0d timeout=%b expected n=3 comps=0 timeout=0", n, comps, timeout);
        end
        nf_mode = 0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_reset_mid();
        int n, comps;
        target = 0;
        start_edge();
        for (int i = 0; i <= 8; i++) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (obs() !== V_GETMEM) begin
            errors++;
            $display("FAIL third_getmem: got %b expected %b", obs(), V_GETMEM);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL async_reset_mid: got %b expected %b", obs(), V_IDLE);
        end
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (obs() !== V_IDLE) begin
                errors++;
                $display("FAIL quiet_after_reset[%0d]: got %b expected %b", i, obs(), V_IDLE);
            end
        end
        target = 1;
        start_edge();
        wait_done(20, n, comps);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL search_after_reset: got %0d expected 5", n);
        end
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_rd_lat3();
        int runs [8];
        int exp_runs [8];
        int run, run_idx, comps, done_at;
        exp_runs = '{3, 4, 4, 4, 4, 4, 4, 1};
        run      = 0;
        run_idx  = 0;
        comps    = 0;
        done_at  = -1;
        for (int j = 0; j < 8; j++) runs[j] = 0;
        @(negedge clock);
        start3 = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if ({set_l3, set_r3, set_m3, load_a3, done3} == 5'b00100) begin
                run++;
            end else begin
                if (run > 0) begin
                    if (run_idx < 8) runs[run_idx] = run;
                    run_idx++;
                    run = 0;
                end
                if (set_l3 && set_r3 && set_m3) comps++;
            end
            if (i > 0 && done3) begin
                done_at = i;
                break;
            end
        end
        checks++;
        if (done_at !== 37) begin
            errors++;
            $display("FAIL rdlat3_done_cycle: got %0d expected 37", done_at);
        end
        checks++;
        if (comps !== 7 || run_idx !== 8) begin
            errors++;
            $display("FAIL rdlat3_probe_count: got comps=%0d runs=%0d expected comps=7 runs=8", comps, run_idx);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (runs[j] !== exp_runs[j]) begin
                errors++;
                $display("FAIL rdlat3_setm_run[%0d]: got %0d expected %0d", j, runs[j], exp_runs[j]);
            end
        end
        checks++;
        if (timeout3 !== 1'b1) begin
            errors++;
            $display("FAIL rdlat3_timeout: got %b expected 1", timeout3);
        end
        @(negedge clock);
        start3 = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        test_reset();
        test_found_first();
        test_found_fifth();
        test_timeout();
        test_back_to_back();
        test_nf_getmem();
        test_reset_mid();
        test_rd_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
